// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_pkg
// Brief   : Shared types, funct3 codes and helpers for the load/store unit.
// Revision: 1.0
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Wide enough for the largest allowed BUS_TIMEOUT (255).
    localparam int LSU_TMO_W = 8;

    // Unrecognised encodings fall back to a full-word access.
    function automatic lsu_size_e lsu_size(input logic we, input logic [2:0] funct3);
        if (funct3 == F3_LB || (!we && funct3 == F3_LBU))
            return SZ_B;
        else if (funct3 == F3_LH || (!we && funct3 == F3_LHU))
            return SZ_H;
        else
            return SZ_W;
    endfunction

    function automatic logic lsu_legal(input logic we, input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            F3_LB:   ok = 1'b1;
            F3_LH:   ok = !addr_lo[0];
            F3_LW:   ok = (addr_lo == 2'b00);
            F3_LBU:  ok = !we;
            F3_LHU:  ok = !we && !addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_load_align
// Brief   : Selects the addressed byte/half of a read word and extends it.
// Revision: 1.0
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (addr_lo)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (funct3)
            F3_LB:   result = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  result = {24'h0, w_byte};
            F3_LH:   result = {{16{w_half[15]}}, w_half};
            F3_LHU:  result = {16'h0, w_half};
            default: result = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : load_store_unit
// Brief   : Single-access LSU bridging the execute stage to a req/gnt/rvalid
//           data bus. Optional LSU_MISALIGN_TRAP_EN traps misaligned/illegal
//           accesses without bus activity.
// Revision: 1.0
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [LSU_TMO_W-1:0] c_tmo_last = LSU_TMO_W'(BUS_TIMEOUT - 1);

    lsu_state_e             r_state;
    lsu_state_e             w_next;
    logic                   r_we;
    logic [2:0]             r_funct3;
    logic [1:0]             r_addr_lo;
    logic [LSU_TMO_W-1:0]   r_cnt;

    lsu_size_e              w_size;
    logic [3:0]             w_be;
    logic [31:0]            w_wdata;
    logic                   w_trap;
    logic                   w_tmo;
    logic [31:0]            w_load_data;

    always_comb begin
        w_size = lsu_size(req_we, req_funct3);
        case (w_size)
            SZ_B: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            SZ_H: begin
                w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = req_wdata;
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap = !lsu_legal(req_we, req_funct3, req_addr[1:0]);
`else
    assign w_trap = 1'b0;
`endif

    assign w_tmo = (r_cnt == c_tmo_last);

    lsu_load_align u_align (
        .rdata   (mem_rdata),
        .addr_lo (r_addr_lo),
        .funct3  (r_funct3),
        .result  (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        stall     = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    stall  = 1'b1;
                    w_next = w_trap ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (mem_gnt)
                    w_next = ST_WAIT;
                else if (w_tmo)
                    w_next = ST_RESP;
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (mem_rvalid)
                    w_next = ST_RESP;
                else if (w_tmo)
                    w_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                w_next    = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_we      <= 1'b0;
            r_funct3  <= 3'b000;
            r_addr_lo <= 2'b00;
            r_cnt     <= '0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
        end else begin
            // Counter restarts on every state change so REQ and WAIT each get
            // a full BUS_TIMEOUT budget.
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_state == ST_REQ || r_state == ST_WAIT)
                r_cnt <= r_cnt + LSU_TMO_W'(1);

            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we      <= req_we;
                        r_funct3  <= req_funct3;
                        r_addr_lo <= req_addr[1:0];
                        rsp_rdata <= 32'h0;
                        rsp_err   <= w_trap;
                        if (!w_trap) begin
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= w_be;
                            mem_wdata <= w_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                    end else if (w_tmo) begin
                        mem_req   <= 1'b0;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'h0;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        rsp_rdata <= r_we ? 32'h0 : w_load_data;
                        rsp_err   <= 1'b0;
                    end else if (w_tmo) begin
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'h0;
                    end
                end
                ST_RESP: begin
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_load_store_unit
// Brief   : Scoreboard bench for load_store_unit with a delay-programmable bus.
// Revision: 1.0
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.BUS_TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // One access: drive the request at a negedge (cycle 0), then play the bus
    // slave with gnt after gnt_dly waiting REQ cycles and rvalid after rv_dly
    // waiting WAIT cycles, comparing against the scoreboard on rsp_valid.
    task automatic run_access(
        input string       name,
        input logic        we,
        input logic [2:0]  f3,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input int          gnt_dly,
        input int          rv_dly,
        input logic        give_rv,
        input logic [31:0] rd,
        input logic [3:0]  exp_be,
        input logic [31:0] exp_wd,
        input int          exp_req_cyc,
        input logic [31:0] exp_rdata,
        input logic        exp_err,
        input int          exp_lat
    );
        exp_t e;
        exp_t x;
        int   req_cyc;
        int   wait_cyc;
        logic granted;
        logic seen_req;
        logic done;

        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_lat;
        sb_q.push_back(e);
        #1 check_eq({name, "_stall_c0"}, {31'h0, stall}, 32'h1);

        req_cyc  = 0;
        wait_cyc = 0;
        granted  = 1'b0;
        seen_req = 1'b0;
        done     = 1'b0;
        for (int k = 1; k <= 100 && !done; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    check_eq({name, "_unexpected_rsp"}, 32'h1, 32'h0);
                end else begin
                    x = sb_q.pop_front();
                    check_eq({name, "_rdata"}, rsp_rdata, x.rdata);
                    check_eq({name, "_err"}, {31'h0, rsp_err}, {31'h0, x.err});
                    if (x.lat >= 0)
                        check_eq({name, "_latency"}, 32'(k), 32'(x.lat));
                end
                check_eq({name, "_stall_rsp"}, {31'h0, stall}, 32'h0);
                check_eq({name, "_req_cycles"}, 32'(req_cyc), 32'(exp_req_cyc));
                req_valid  = 1'b0;
                mem_gnt    = 1'b0;
                mem_rvalid = 1'b0;
                done       = 1'b1;
            end else begin
                if (mem_req) begin
                    req_cyc++;
                    if (!seen_req) begin
                        seen_req = 1'b1;
                        check_eq({name, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
                        check_eq({name, "_mem_be"}, {28'h0, mem_be}, {28'h0, exp_be});
                        check_eq({name, "_mem_we"}, {31'h0, mem_we}, {31'h0, we});
                        if (we)
                            check_eq({name, "_mem_wdata"}, mem_wdata, exp_wd);
                    end
                end else if (granted) begin
                    wait_cyc++;
                end
                mem_gnt = mem_req && (req_cyc > gnt_dly);
                if (mem_gnt)
                    granted = 1'b1;
                mem_rvalid = give_rv && granted && !mem_req && (wait_cyc > rv_dly);
                mem_rdata  = mem_rvalid ? rd : $urandom;
            end
        end
        if (!done) begin
            check_eq({name, "_no_response"}, 32'h0, 32'h1);
            req_valid  = 1'b0;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got hung expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic late_seen;

        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;

        repeat (3) @(negedge clk);
        check_eq("rst_stall",     {31'h0, stall},     32'h0);
        check_eq("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check_eq("rst_rsp_err",   {31'h0, rsp_err},   32'h0);
        check_eq("rst_rsp_rdata", rsp_rdata,          32'h0);
        check_eq("rst_mem_ctl",   {30'h0, mem_req, mem_we}, 32'h0);
        check_eq("rst_mem_addr",  mem_addr,           32'h0);
        check_eq("rst_mem_be",    {28'h0, mem_be},    32'h0);
        check_eq("rst_mem_wdata", mem_wdata,          32'h0);
        rst = 1'b1;
        @(negedge clk);

        //         name    we    f3      addr          wdata          gd rd rv    mem_rdata      be       wdata_exp      rq rdata          err  lat
        run_access("lw",   1'b0, 3'b010, 32'h0000_0100, 32'h0,        0, 0, 1'b1, 32'hDEAD_BEEF, 4'b1111, 32'h0,         1, 32'hDEAD_BEEF, 1'b0, 3);
        run_access("lb",   1'b0, 3'b000, 32'h0000_0103, 32'h0,        0, 0, 1'b1, 32'h8011_2233, 4'b1000, 32'h0,         1, 32'hFFFF_FF80, 1'b0, 3);
        run_access("lbu",  1'b0, 3'b100, 32'h0000_0103, 32'h0,        0, 0, 1'b1, 32'h8011_2233, 4'b1000, 32'h0,         1, 32'h0000_0080, 1'b0, 3);
        run_access("lhu",  1'b0, 3'b101, 32'h0000_0102, 32'h0,        0, 0, 1'b1, 32'h8011_2233, 4'b1100, 32'h0,         1, 32'h0000_8011, 1'b0, 3);
        run_access("lh",   1'b0, 3'b001, 32'h0000_0102, 32'h0,        0, 0, 1'b1, 32'h8011_2233, 4'b1100, 32'h0,         1, 32'hFFFF_8011, 1'b0, 3);
        run_access("sb",   1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 3, 0, 1'b1, 32'h0,        4'b0010, 32'hA5A5_A5A5, 4, 32'h0,         1'b0, 6);
        run_access("sh",   1'b1, 3'b001, 32'h0000_0202, 32'h1234_BEEF, 0, 2, 1'b1, 32'h0,        4'b1100, 32'hBEEF_BEEF, 1, 32'h0,         1'b0, 5);
        run_access("lb_p", 1'b0, 3'b000, 32'h0000_0101, 32'h0,        1, 1, 1'b1, 32'h0000_7F00, 4'b0010, 32'h0,         2, 32'h0000_007F, 1'b0, 5);
        run_access("sw",   1'b1, 3'b010, 32'h0000_0304, 32'hCAFE_F00D, 0, 0, 1'b1, 32'h0,        4'b1111, 32'hCAFE_F00D, 1, 32'h0,         1'b0, 3);

        // Bus never completes: error response, then a late rvalid is ignored.
        run_access("tmo",  1'b0, 3'b010, 32'h0000_0400, 32'h0,        0, 0, 1'b0, 32'h0,        4'b1111, 32'h0,         1, 32'h0,         1'b1, -1);
        late_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid)
                late_seen = 1'b1;
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h1234_5678;
        end
        @(negedge clk);
        if (rsp_valid)
            late_seen = 1'b1;
        mem_rvalid = 1'b0;
        check_eq("late_rvalid_rsp", {31'h0, late_seen}, 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
        run_access("lw_mis", 1'b0, 3'b010, 32'h0000_0102, 32'h0,     0, 0, 1'b1, 32'h5555_AAAA, 4'b1111, 32'h0,         0, 32'h0,         1'b1, 1);
`else
        run_access("lw_mis", 1'b0, 3'b010, 32'h0000_0102, 32'h0,     0, 0, 1'b1, 32'h5555_AAAA, 4'b1111, 32'h0,         1, 32'h5555_AAAA, 1'b0, 3);
`endif

        // Reset asserted while the access sits in WAIT aborts it silently.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0500;
        @(negedge clk);
        check_eq("rst_abort_req", {31'h0, mem_req}, 32'h1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check_eq("rst_abort_wait_stall", {31'h0, stall}, 32'h1);
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_abort_mem_req",   {31'h0, mem_req},   32'h0);
        check_eq("rst_abort_stall",     {31'h0, stall},     32'h0);
        check_eq("rst_abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        rst        = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_0000;
        late_seen  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid)
                late_seen = 1'b1;
        end
        mem_rvalid = 1'b0;
        check_eq("rst_abort_no_rsp", {31'h0, late_seen}, 32'h0);

        // Access after the abort still works normally.
        run_access("post_rst", 1'b0, 3'b101, 32'h0000_0600, 32'h0,   0, 0, 1'b1, 32'h1111_F00F, 4'b0011, 32'h0,         1, 32'h0000_F00F, 1'b0, 3);

        check_eq("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
